ps2_rx_fifo: RTL and testbench

- Parametrised PS/2 host-side receiver, successor to the single-byte keyboard sampler.
- Synchronises ps2_clk/ps2_data into clk and deframes 11-bit frames with start, parity and stop checking.
- Has a watchdog that aborts stalled partial frames and optionally folds E0/F0 prefixes into flags.
- Queues decoded bytes in a FIFO drained through a valid/ready port; feeds the NPC keyboard MMIO device.

---
 rtl/ps2_rx_fifo.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ps2_rx_fifo
//
// PS/2 host-side receiver. The raw, asynchronous PS/2 clock and data lines are
// synchronised into clk. Each 11-bit frame is deframed and checked:
//   start bit 0, eight data bits LSB first, odd parity, stop bit 1.
// A watchdog abandons a frame whose falling edges stop arriving. With DECODE=1,
// the E0 (extended) and F0 (break) prefix bytes are folded into flags on the
// next real byte. Decoded bytes are queued in a first-word-fall-through FIFO
// that is drained through a valid/ready port.
//
// Parameters
//   SYNC_STAGES     synchroniser depth for ps2_clk / ps2_data (>= 2)
//   FIFO_DEPTH      output FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYCLES  clk cycles allowed between falling edges in a frame;
//                   0 disables the watchdog
//   DECODE          1 = absorb E0/F0 prefixes into flags, 0 = raw bytes
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   ps2_clk      raw PS/2 clock (asynchronous)
//   ps2_data     raw PS/2 data (asynchronous)
//   out_valid    FIFO holds at least one entry
//   out_ready    consumer takes the head entry this cycle
//   out_data     head scancode byte (0 when empty)
//   out_break    head entry was preceded by F0
//   out_ext      head entry was preceded by E0
//   fifo_count   current FIFO occupancy
//   parity_err   one-cycle pulse: frame had bad parity
//   frame_err    one-cycle pulse: bad start or stop bit
//   timeout_err  one-cycle pulse: partial frame abandoned by the watchdog
//   overflow     one-cycle pulse: byte dropped because the FIFO was full
// -----------------------------------------------------------------------------
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 3,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DECODE         = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_data,
  output logic                          out_break,
  output logic                          out_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          timeout_err,
  output logic                          overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [WDW-1:0] WD_LIMIT   = WDW'(TIMEOUT_CYCLES);
  localparam logic [3:0]     STOP_BIT   = 4'd10;
  localparam logic [7:0]     BYTE_BREAK = 8'hF0;
  localparam logic [7:0]     BYTE_EXT   = 8'hE0;

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers. Both chains reset to 1 (idle bus) so releasing reset can
  // never look like a falling edge. Index 0 is the newest sample.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-2:0] data_sync;
  logic                   fall;
  logic                   bit_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before the edge, independent of statement order.
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
    end
  end

  // The data chain stops one stage short of the clock chain: the data bit is
  // taken from the stage aligned with the newer half of the edge detector.
  generate
    if (SYNC_STAGES > 2) begin : g_data_sync
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_sync <= '1;
        end else begin
          data_sync <= {data_sync[SYNC_STAGES-3:0], ps2_data};
        end
      end
    end else begin : g_data_sync_1
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_sync <= '1;
        end else begin
          data_sync <= ps2_data;
        end
      end
    end
  endgenerate

  assign fall   = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign bit_in = data_sync[SYNC_STAGES-2];

  // ---------------------------------------------------------------------------
  // Deframing FSM with watchdog and prefix decode.
  // shreg collects d0..d7 then the parity bit; after nine shifts d0 sits in
  // bit 0 and parity in bit 8.
  // ---------------------------------------------------------------------------
  state_t           state, state_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [8:0]       shreg, shreg_n;
  logic [WDW-1:0]   wd_cnt, wd_cnt_n;
  logic             pend_break, pend_break_n;
  logic             pend_ext, pend_ext_n;
  logic             push_req, push_req_n;
  logic [9:0]       push_word, push_word_n;
  logic             parity_err_n, frame_err_n, timeout_err_n;
  logic             wd_hit;
  logic             fifo_full;

  assign wd_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LIMIT);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    shreg_n       = shreg;
    wd_cnt_n      = wd_cnt;
    pend_break_n  = pend_break;
    pend_ext_n    = pend_ext;
    push_req_n    = 1'b0;
    push_word_n   = push_word;
    parity_err_n  = 1'b0;
    frame_err_n   = 1'b0;
    timeout_err_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (fall) begin
          if (!bit_in) begin
            state_n   = RECV;
            bit_cnt_n = 4'd1;
            wd_cnt_n  = '0;
          end else begin
            // A falling edge with data high cannot be a start bit.
            frame_err_n  = 1'b1;
            pend_break_n = 1'b0;
            pend_ext_n   = 1'b0;
          end
        end
      end

      RECV: begin
        if (wd_hit) begin
          // Stalled frame: drop the partial byte and any pending prefixes.
          timeout_err_n = 1'b1;
          state_n       = IDLE;
          bit_cnt_n     = '0;
          pend_break_n  = 1'b0;
          pend_ext_n    = 1'b0;
        end else if (fall) begin
          wd_cnt_n = '0;
          if (bit_cnt != STOP_BIT) begin
            shreg_n   = {bit_in, shreg[8:1]};
            bit_cnt_n = bit_cnt + 4'd1;
          end else begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            if (!(^shreg)) begin
              // Odd parity: data plus parity bit must hold an odd number of 1s.
              parity_err_n = 1'b1;
              pend_break_n = 1'b0;
              pend_ext_n   = 1'b0;
            end else if (!bit_in) begin
              frame_err_n  = 1'b1;
              pend_break_n = 1'b0;
              pend_ext_n   = 1'b0;
            end else if ((DECODE != 0) && (shreg[7:0] == BYTE_BREAK)) begin
              pend_break_n = 1'b1;
            end else if ((DECODE != 0) && (shreg[7:0] == BYTE_EXT)) begin
              pend_ext_n = 1'b1;
            end else begin
              push_req_n   = 1'b1;
              push_word_n  = (DECODE != 0) ? {pend_break, pend_ext, shreg[7:0]}
                                           : {2'b00, shreg[7:0]};
              pend_break_n = 1'b0;
              pend_ext_n   = 1'b0;
            end
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          wd_cnt_n = wd_cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase

    // A byte dropped on overflow also discards any prefix seen since.
    if (push_req && fifo_full) begin
      pend_break_n = 1'b0;
      pend_ext_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      wd_cnt      <= '0;
      pend_break  <= 1'b0;
      pend_ext    <= 1'b0;
      push_req    <= 1'b0;
      push_word   <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      wd_cnt      <= wd_cnt_n;
      pend_break  <= pend_break_n;
      pend_ext    <= pend_ext_n;
      push_req    <= push_req_n;
      push_word   <= push_word_n;
      parity_err  <= parity_err_n;
      frame_err   <= frame_err_n;
      timeout_err <= timeout_err_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO: first-word fall-through, entries are {break, ext, byte}.
  // Full is judged before any pop in the same cycle, so a push into a full
  // FIFO is dropped even when the consumer is reading.
  // ---------------------------------------------------------------------------
  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;
  logic [9:0]    head;

  assign fifo_full = (count == FULL_COUNT);
  assign do_push   = push_req & ~fifo_full;
  assign do_pop    = out_valid & out_ready;

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are live, and the outputs are gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo FIFO_DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_req & fifo_full;
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? head[7:0] : 8'h00;
  assign out_break  = out_valid & head[9];
  assign out_ext    = out_valid & head[8];
  assign fifo_count = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ps2_rx_fifo
//
// Directed bench for ps2_rx_fifo (FIFO_DEPTH=4, short watchdog). Frames are
// built from byte values; a queue-based model applies the decode and FIFO
// rules per received byte and one compare process checks the FIFO outputs
// every cycle against it. Pulse outputs are counted and compared with the
// model's expected counts at checkpoints; literal checks pin key results.
// -----------------------------------------------------------------------------
module tb_ps2_rx_fifo;

  localparam int DEPTH = 4;
  localparam int TMO   = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_break;
  logic       out_ext;
  logic [2:0] fifo_count;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_err;
  logic       overflow;

  ps2_rx_fifo #(
    .SYNC_STAGES   (3),
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO),
    .DECODE        (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_break  (out_break),
    .out_ext    (out_ext),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: queue of {break, ext, byte}, pending prefixes, expected pulse counts.
  logic [9:0] q[$];
  bit         m_pb = 1'b0;
  bit         m_pe = 1'b0;
  bit         model_ok = 1'b0;
  int exp_perr = 0, exp_ferr = 0, exp_terr = 0, exp_ovf = 0;
  int obs_perr = 0, obs_ferr = 0, obs_terr = 0, obs_ovf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                             input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  // Apply the receiver's rules to one completed frame.
  task automatic model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_par) begin
      exp_perr++;
      m_pb = 1'b0; m_pe = 1'b0;
    end else if (bad_stop) begin
      exp_ferr++;
      m_pb = 1'b0; m_pe = 1'b0;
    end else if (b == 8'hF0) begin
      m_pb = 1'b1;
    end else if (b == 8'hE0) begin
      m_pe = 1'b1;
    end else begin
      if (q.size() == DEPTH) exp_ovf++;
      else q.push_back({m_pb, m_pe, b});
      m_pb = 1'b0; m_pe = 1'b0;
    end
  endtask

  // One bit cell: data set while clock high, falling edges 40 clk apart.
  task automatic send_bit(input logic v);
    ps2_data = v;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = make_frame(b, bad_par, bad_stop);
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    model_ok = 1'b0;  // FIFO may change anywhere inside the stop-bit cell
    send_bit(f[10]);
    model_byte(b, bad_par, bad_stop);
    model_ok = 1'b1;
  endtask

  task automatic drain_one();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_perr"}, obs_perr, exp_perr);
    check({tag, "_ferr"}, obs_ferr, exp_ferr);
    check({tag, "_terr"}, obs_terr, exp_terr);
    check({tag, "_ovf"},  obs_ovf,  exp_ovf);
  endtask

  // Compare process: sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    logic [9:0] head;
    #2;
    if (!reset) begin
      obs_perr += int'(parity_err);
      obs_ferr += int'(frame_err);
      obs_terr += int'(timeout_err);
      obs_ovf  += int'(overflow);
      if (model_ok) begin
        check("cyc_valid", out_valid, q.size() != 0);
        check("cyc_count", fifo_count, q.size());
        if (q.size() != 0) begin
          head = q[0];
          check("cyc_data", out_data, head[7:0]);
          check("cyc_break", out_break, head[9]);
          check("cyc_ext", out_ext, head[8]);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    logic [10:0] f;
    reset     = 1'b1;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    out_ready = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_pulses", {parity_err, frame_err, timeout_err, overflow}, 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    model_ok = 1'b1;
    repeat (10) @(negedge clk);

    // Plain frame, held with out_ready low, then a single pop.
    send_frame(8'h1C, 0, 0);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 8'h1C);
    check("t1_flags", {out_break, out_ext}, 2'b00);
    check("t1_count", fifo_count, 1);
    drain_one();
    @(negedge clk);
    check("t1_count_after_pop", fifo_count, 0);

    // Prefix folding, including E1 which is an ordinary byte.
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    check("t2_count", fifo_count, 1);
    check("t2_data", out_data, 8'h1C);
    check("t2_flags", {out_break, out_ext}, 2'b10);
    drain_one();
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    check("t2_data2", out_data, 8'h75);
    check("t2_flags2", {out_break, out_ext}, 2'b11);
    drain_one();
    send_frame(8'hF0, 0, 0);
    send_frame(8'hE1, 0, 0);
    check("t2_e1", {out_break, out_ext, out_data}, {2'b10, 8'hE1});
    drain_one();

    // Bad parity discards the byte and the pending prefix.
    send_frame(8'hE0, 0, 0);
    send_frame(8'h1C, 1, 0);
    check("t3_perr_lit", obs_perr, 1);
    check("t3_count", fifo_count, 0);
    send_frame(8'h32, 0, 0);
    check("t3_data", {out_break, out_ext, out_data}, {2'b00, 8'h32});
    drain_one();

    // Bad stop bit.
    send_frame(8'h55, 0, 1);
    check("t3_ferr_lit", obs_ferr, 1);
    check_pulses("t3");

    // Partial frame then silence: watchdog fires once.
    f = make_frame(8'h1C, 0, 0);
    for (int i = 0; i < 5; i++) send_bit(f[i]);
    repeat (TMO + 100) @(negedge clk);
    exp_terr++;
    m_pb = 1'b0; m_pe = 1'b0;
    check("t4_terr_lit", obs_terr, 1);
    send_frame(8'h1C, 0, 0);
    check("t4_data", out_data, 8'h1C);
    check_pulses("t4");
    drain_one();

    // Overflow: fifth byte dropped, first four drain in order.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0);
    check("t5_ovf_lit", obs_ovf, 1);
    check("t5_count", fifo_count, 4);
    for (int i = 1; i <= 4; i++) begin
      check("t5_drain", out_data, i);
      drain_one();
      @(negedge clk);
    end
    check("t5_empty", out_valid, 0);
    check_pulses("t5");

    // Reset during bit 6 with an entry queued and a break prefix pending.
    send_frame(8'h32, 0, 0);
    send_frame(8'hF0, 0, 0);
    f = make_frame(8'h1C, 0, 0);
    for (int i = 0; i < 6; i++) send_bit(f[i]);
    ps2_data = f[6];
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (5) @(negedge clk);
    model_ok = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_data", out_data, 0);
    check("t6_flags", {out_break, out_ext}, 2'b00);
    check("t6_count", fifo_count, 0);
    check("t6_pulses", {parity_err, frame_err, timeout_err, overflow}, 0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_pb = 1'b0; m_pe = 1'b0;
    model_ok = 1'b1;
    repeat (20) @(negedge clk);
    check_pulses("t6_quiet");
    send_frame(8'h1C, 0, 0);
    check("t6_rx", {out_break, out_ext, out_data}, {2'b00, 8'h1C});
    check("t6_rx_count", fifo_count, 1);
    drain_one();
    repeat (10) @(negedge clk);
    check_pulses("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
